rsa_modexp_decrypt: RTL and testbench
=====================================

// Module: rsa_modexp_decrypt
// PURPOSE
//  Decryption stage that sits directly downstream of the RSA encrypt/key-gen top.
//  Consumes the ciphertext, private exponent d and modulus n produced there.
//  Computes M = C^d mod n by left-to-right, constant-time square-and-multiply.
//  Each modular multiply is an iterative Blakley shift-add (one bit/cycle, no divider).
// PARAMETERS
//  W  16  operand width of C, d, n and M (bits)
// PORTS
//  clk    in   1  single clock; all state updates on rising edge
//  rst    in   1  asynchronous, active-high reset
//  start  in   1  1-cycle request; sampled only in IDLE
//  C      in   W  ciphertext (may be >= n)
//  d      in   W  private exponent
//  n      in   W  modulus
//  M      out  W  recovered plaintext; held until next accepted start
//  done   out  1  1-cycle pulse; M valid from this cycle on
//  busy   out  1  high from the cycle after start is accepted until done
//  err    out  1  set with done when n==0; cleared on next accepted start
// BEHAVIOUR
//  Reset: M=0, done=0, busy=0, err=0, FSM=IDLE, all internal regs 0. Takes effect mid-operation too.
//  States: IDLE -> REDUCE -> {SQR -> MUL} x W -> DONE -> IDLE.
//  IDLE: on start, latch C, d, n into internal regs; res<=1; bit counter<=W-1; err<=0.
//   n==0: go to DONE with M<=0, err<=1. n==1: go to DONE with M<=0.
//   Otherwise go to REDUCE.
//  REDUCE (W cycles): base = (1*C) mod n via the modmul datapath with a=1, b=C.
//  modmul(a,b), a<n, W cycles, MSB of b first; r starts at 0. Per cycle:
//   t=2r; if t>=n t-=n; t+=b[i]?a:0; if t>=n t-=n; r<=t.
//   Internal width W+1 bits; no overflow is permitted.
//  SQR (W cycles): res = modmul(res,res).
//  MUL (W cycles): p = modmul(res,base), always computed.
//   Commit res<=p only if d[k]==1, where k = current exponent bit (MSB first).
//   Timing is therefore independent of d.
//  After MUL of bit 0 go to DONE; otherwise decrement k and go to SQR.
//  DONE (1 cycle): M<=res (or 0 per the n<2 rules above), done=1, busy=0. Next state IDLE.
//  Latency: with n>=2, done is high exactly 1+W+2*W*W cycles after the start-sampling edge.
//   This is 529 cycles for W=16. With n<2, done is high on the 2nd cycle after that edge.
//  busy==1 in REDUCE/SQR/MUL; 0 in IDLE/DONE. start while busy or in DONE is ignored (no queueing).
//  Changes to C, d, n after acceptance have no effect.
//  d==0 gives M=1 (for n>=2). C>=n is handled by REDUCE. C==0 with d>0 gives M=0.
// TESTING
//  T1 basic: n=33, d=7, C=31, start pulse -> done after 529 cycles, M=4, err=0.
//  T2 round trip: n=3551, exp=5, C=1256 -> X.
//     Then n=3551, d=1373, C=X -> M=1256 (d=1373 is 5^-1 mod 3432).
//  T3 reduction/edges: n=33, d=1, C=40000 -> M=4. n=33, d=0, C=31 -> M=1.
//     n=1 -> M=0, err=0, done 2 cycles after start.
//  T4 n=0: start -> done 2 cycles later, M=0, err=1.
//     Next start with n=33, d=7, C=31 -> err cleared, M=4.
//  T5 start re-asserted at cycles 10 and 300 of an operation -> ignored.
//     Single done at cycle 529; the result matches the first request's operands.
//  T6 rst pulsed mid-REDUCE and mid-MUL (async, off-edge) -> outputs 0 immediately, busy=0.
//     A fresh start then completes correctly (T1 values).

Source files
------------

// File: rtl/rsa_modexp_decrypt.sv
// RSA decryption stage: M = C^d mod n using constant-time left-to-right
// square-and-multiply. Each modular multiply is a bit-serial Blakley
// shift-add that takes W cycles, MSB of the multiplier first.
module rsa_modexp_decrypt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] C,
  input  logic [W-1:0] d,
  input  logic [W-1:0] n,
  output logic [W-1:0] M,
  output logic         done,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LastIdx = CW'(W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReduce,
    StSqr,
    StMul,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  d_q, d_d;
  logic [W-1:0]  n_q, n_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  base_q, base_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] k_q, k_d;
  logic [W-1:0]  m_q, m_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [W-1:0]  op_a, op_b;
  logic [W:0]    wide_n;
  logic [W:0]    t;
  logic [W-1:0]  prod;
  logic          last;

  // One Blakley step: r <- (2r + b[i]*a) mod n, kept below n at every stage.
  always_comb begin
    op_a   = '0;
    op_b   = '0;
    unique case (state_q)
      StReduce: begin
        op_a = W'(1);
        op_b = c_q;
      end
      StSqr: begin
        op_a = res_q;
        op_b = res_q;
      end
      StMul: begin
        op_a = res_q;
        op_b = base_q;
      end
      default: ;
    endcase
    wide_n = {1'b0, n_q};
    t      = {acc_q, 1'b0};
    if (t >= wide_n) t = t - wide_n;
    if (op_b[cnt_q]) t = t + {1'b0, op_a};
    if (t >= wide_n) t = t - wide_n;
    prod   = t[W-1:0];
    last   = (cnt_q == '0);
  end

  // Next-state and datapath register updates for the exponentiation sequence.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    n_d     = n_q;
    res_d   = res_q;
    base_d  = base_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    m_d     = m_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          c_d   = C;
          d_d   = d;
          n_d   = n;
          res_d = W'(1);
          acc_d = '0;
          cnt_d = LastIdx;
          k_d   = LastIdx;
          err_d = 1'b0;
          if ((n == '0) || (n == W'(1))) state_d = StDone;
          else                           state_d = StReduce;
        end
      end
      StReduce: begin
        acc_d = prod;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          base_d  = prod;
          acc_d   = '0;
          cnt_d   = LastIdx;
          state_d = StSqr;
        end
      end
      StSqr: begin
        acc_d = prod;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          res_d   = prod;
          acc_d   = '0;
          cnt_d   = LastIdx;
          state_d = StMul;
        end
      end
      StMul: begin
        acc_d = prod;
        cnt_d = cnt_q - CW'(1);
        if (last) begin
          // Product is always computed; only the commit depends on the key bit.
          if (d_q[k_q]) res_d = prod;
          acc_d = '0;
          cnt_d = LastIdx;
          if (k_q == '0) begin
            state_d = StDone;
          end else begin
            k_d     = k_q - CW'(1);
            state_d = StSqr;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (n_q == '0) begin
          m_d   = '0;
          err_d = 1'b1;
        end else if (n_q == W'(1)) begin
          m_d = '0;
        end else begin
          m_d = res_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      n_q     <= '0;
      res_q   <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      m_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      n_q     <= n_d;
      res_q   <= res_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      m_q     <= m_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Outputs come straight from registers or decoded state.
  always_comb begin
    M    = m_q;
    done = done_q;
    err  = err_q;
    busy = (state_q == StReduce) || (state_q == StSqr) || (state_q == StMul);
  end

endmodule

// File: tb/tb_rsa_modexp_decrypt.sv
// Self-checking bench for rsa_modexp_decrypt: vector table plus hand-written
// sequences for round trip, ignored restarts and asynchronous reset.
module tb_rsa_modexp_decrypt;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] C, d, n;
  logic [15:0] M;
  logic        done, busy, err;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [15:0] m;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic [15:0] c;
    logic [15:0] d;
    logic [15:0] n;
    logic [15:0] m;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];

  rsa_modexp_decrypt #(.W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .C    (C),
    .d    (d),
    .n    (n),
    .M    (M),
    .done (done),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference exponentiation with ordinary 64-bit arithmetic.
  function automatic logic [15:0] model(input logic [15:0] c, input logic [15:0] e,
                                        input logic [15:0] m);
    longint r, b;
    if (m < 16'd2) return 16'd0;
    r = 1;
    b = longint'(c) % longint'(m);
    for (int i = 15; i >= 0; i--) begin
      r = (r * r) % longint'(m);
      if (e[i]) r = (r * b) % longint'(m);
    end
    return r[15:0];
  endfunction

  task automatic run_op(input string tag, input logic [15:0] c_in, input logic [15:0] d_in,
                        input logic [15:0] n_in, input logic [15:0] m_exp, input bit retrig,
                        output logic [15:0] m_got);
    exp_t e;
    int   lat;
    e.m   = m_exp;
    e.err = (n_in == 16'd0);
    e.lat = (n_in < 16'd2) ? 1 : 529;
    @(negedge clk);
    C = c_in; d = d_in; n = n_in; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    C = 16'($urandom); d = 16'($urandom); n = 16'($urandom);
    check({tag, " busy_after_start"}, 32'(busy), 32'(n_in >= 16'd2));
    lat = 0;
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
      start = retrig && (lat == 10 || lat == 300 || lat == 528);
    end
    start = 1'b0;
    e = sb.pop_front();
    check({tag, " done_seen"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(e.lat));
    check({tag, " M"}, 32'(M), 32'(e.m));
    check({tag, " err"}, 32'(err), 32'(e.err));
    check({tag, " busy_at_done"}, 32'(busy), 32'd0);
    m_got = M;
    @(negedge clk);
    check({tag, " done_pulse"}, 32'(done), 32'd0);
    check({tag, " M_held"}, 32'(M), 32'(e.m));
  endtask

  task automatic abort_op(input string tag, input int at_lat);
    @(negedge clk);
    C = 16'd31; d = 16'd7; n = 16'd33; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (at_lat) @(negedge clk);
    check({tag, " busy_before_rst"}, 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check({tag, " M_rst"}, 32'(M), 32'd0);
    check({tag, " busy_rst"}, 32'(busy), 32'd0);
    check({tag, " done_rst"}, 32'(done), 32'd0);
    check({tag, " err_rst"}, 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, " idle_after_rst"}, 32'({busy, done}), 32'd0);
  endtask

  initial begin
    logic [15:0] got, x;
    vecs[0] = '{c: 16'd31,    d: 16'd7,     n: 16'd33,    m: 16'd4};
    vecs[1] = '{c: 16'd40000, d: 16'd1,     n: 16'd33,    m: 16'd4};
    vecs[2] = '{c: 16'd31,    d: 16'd0,     n: 16'd33,    m: 16'd1};
    vecs[3] = '{c: 16'd31,    d: 16'd7,     n: 16'd1,     m: 16'd0};
    vecs[4] = '{c: 16'd31,    d: 16'd7,     n: 16'd0,     m: 16'd0};
    vecs[5] = '{c: 16'd31,    d: 16'd7,     n: 16'd33,    m: 16'd4};
    vecs[6] = '{c: 16'd0,     d: 16'd3,     n: 16'd33,    m: 16'd0};
    vecs[7] = '{c: 16'd1256,  d: 16'd5,     n: 16'd3551,  m: model(16'd1256, 16'd5, 16'd3551)};
    vecs[8] = '{c: 16'd65535, d: 16'd65535, n: 16'd65521,
                m: model(16'd65535, 16'd65535, 16'd65521)};
    vecs[9] = '{c: 16'd12345, d: 16'd54321, n: 16'd65535,
                m: model(16'd12345, 16'd54321, 16'd65535)};

    rst = 1'b1; start = 1'b0; C = '0; d = '0; n = '0;
    repeat (2) @(negedge clk);
    check("reset M", 32'(M), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].d, vecs[i].n, vecs[i].m, 1'b0, got);
    end

    // Round trip: encrypt with e=5, then decrypt with d=1373.
    x = model(16'd1256, 16'd5, 16'd3551);
    run_op("rt_decrypt", x, 16'd1373, 16'd3551, 16'd1256, 1'b0, got);

    // Restart pulses mid-operation and in the done state must be ignored.
    run_op("retrig", 16'd31, 16'd7, 16'd33, 16'd4, 1'b1, got);

    // Asynchronous reset mid-REDUCE and mid-MUL, then a clean run.
    abort_op("rst_reduce", 5);
    abort_op("rst_mul", 40);
    run_op("after_rst", 16'd31, 16'd7, 16'd33, 16'd4, 1'b0, got);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
